// File: rtl/mc_core.sv
// mc_core: multicycle 3-bit-opcode register machine with handshaked instruction/data memories,
// start/restart sequencing, sticky done and a saturating retired-instruction counter.
module mc_core #(
    parameter int DW = 8,
    parameter int RW = 3,
    parameter int PW = 12,
    parameter int START_ADDR = 0,
    parameter int HALT_ADDR = 128,
    parameter int CW = 16,
    localparam int IW = 3 + 2 * RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic          imem_req,
    output logic [PW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          imem_ack,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic [CW-1:0] retired
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
    localparam logic [PW-1:0] START_PC = PW'(START_ADDR);
    localparam logic [PW-1:0] HALT_PC = PW'(HALT_ADDR);
    localparam logic [2:0] OP_LD = 3'd5;
    localparam logic [2:0] OP_ST = 3'd6;
    localparam logic [2:0] OP_BNZ = 3'd7;
    state_t state;
    logic [PW-1:0] pc, npc;
    logic [IW-1:0] ir;
    logic [DW-1:0] regs [2**RW];
    logic [2:0] op;
    logic [RW-1:0] ra, rb;
    logic [DW-1:0] a, b, alu;
    logic [CW-1:0] ret_inc;
    logic taken;
    assign op = ir[IW-1:IW-3];
    assign ra = ir[2*RW-1:RW];
    assign rb = ir[RW-1:0];
    assign a = regs[ra];
    assign b = regs[rb];
    assign alu = op[2] ? {{(DW-RW){1'b0}}, rb} :
                 op[1] ? (op[0] ? a ^ b : a & b) :
                         (op[0] ? a - b : a + b);
    assign taken = op == OP_BNZ && a != '0;
    assign npc = pc + (taken ? {{(PW-RW){rb[RW-1]}}, rb} : PW'(1));
    assign ret_inc = retired + CW'(retired != '1);
    // Handshake outputs decode straight from the state register so reset kills them at once
    assign done = state == HALT;
    assign busy = state == FETCH || state == EXEC || state == MEM;
    assign imem_req = state == FETCH;
    assign imem_addr = pc;
    assign dmem_req = state == MEM;
    assign dmem_we = state == MEM && op == OP_ST;
    assign dmem_addr = b;
    assign dmem_wdata = a;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc <= START_PC;
            ir <= '0;
            retired <= '0;
            for (int i = 0; i < 2**RW; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE, HALT: if (start) begin
                    pc <= START_PC;
                    retired <= '0;
                    state <= START_PC == HALT_PC ? HALT : FETCH;
                end
                FETCH: if (imem_ack) begin
                    ir <= imem_rdata;
                    state <= EXEC;
                end
                EXEC: if (op == OP_LD || op == OP_ST) state <= MEM;
                else begin
                    if (op != OP_BNZ) regs[ra] <= alu;
                    pc <= npc;
                    retired <= ret_inc;
                    state <= npc == HALT_PC ? HALT : FETCH;
                end
                MEM: if (dmem_ack) begin
                    if (op == OP_LD) regs[ra] <= dmem_rdata;
                    pc <= npc;
                    retired <= ret_inc;
                    state <= npc == HALT_PC ? HALT : FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mc_core.md
Name: mc_core

Overview:
- Multicycle, parametrised successor to the single-cycle top-level datapath.
- Same 3-bit-opcode / two-register-field instruction format, generalised in data width, register count and PC width.
- Instruction and data memories are external, reached over req/ack handshake ports, so wait states are tolerated.
- Adds start/restart sequencing, a sticky done flag and a retired-instruction counter.

Parameters:
- DW, 8, data / register / data-address width.
- RW, 3, register address bits; register count is 2^RW; instruction width IW = 3 + 2*RW.
- PW, 12, program counter width.
- START_ADDR, 0, PC loaded on start.
- HALT_ADDR, 128, PC value that terminates execution.
- CW, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled in IDLE/HALT to begin execution.
- done  out  1  high while in HALT.
- busy  out  1  high in FETCH/EXEC/MEM.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PW  fetch address (= pc).
- imem_rdata  in  IW  instruction word, valid when imem_ack.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_addr  out  DW  data address.
- dmem_wdata  out  DW  store data.
- dmem_rdata  in  DW  load data, valid when dmem_ack.
- dmem_ack  in  1  data access complete.
- retired  out  CW  instructions completed since last start.

Behaviour:
- Instruction fields:
  - op = instr[IW-1:IW-3]
  - ra = instr[2*RW-1:RW] (destination and first operand)
  - rb = instr[RW-1:0] (second operand, immediate, or branch offset)
- Opcodes:
  - 000 ADD: ra = ra + rb
  - 001 SUB: ra = ra - rb
  - 010 AND: ra = ra & rb
  - 011 XOR: ra = ra ^ rb
  - 100 LDI: ra = zero-extended rb field
  - 101 LD: ra = mem[reg[rb]]
  - 110 ST: mem[reg[rb]] = reg[ra]
  - 111 BNZ: if reg[ra] != 0 then pc = pc + sign-extended rb field, else pc = pc + 1
- Arithmetic is modulo 2^DW; PC arithmetic is modulo 2^PW.
- States: IDLE, FETCH, EXEC, MEM, HALT.
- Reset (async, rst_n low):
  - state = IDLE; pc = START_ADDR; all registers = 0; retired = 0.
  - done, busy, imem_req, dmem_req, dmem_we = 0.
  - Request outputs are registered/decoded from state and drop as soon as rst_n falls.
- IDLE / HALT with start = 1:
  - pc <= START_ADDR; retired <= 0.
  - Go to FETCH, or to HALT if START_ADDR == HALT_ADDR.
  - start = 0: remain in place.
- FETCH:
  - imem_req = 1, imem_addr = pc, held stable until imem_ack is sampled high.
  - On ack: latch instruction, go to EXEC.
- EXEC (exactly one cycle):
  - ALU ops and LDI write ra at the clock edge; BNZ updates pc.
  - LD/ST go to MEM; everything else completes here.
- MEM:
  - dmem_req = 1, dmem_addr = reg[rb], dmem_we = (op == ST), dmem_wdata = reg[ra]; all held stable until dmem_ack.
  - On ack: LD writes ra with dmem_rdata; instruction completes.
- Completion:
  - pc <= next pc (BNZ result, else pc + 1); retired <= retired + 1, saturating at all-ones.
  - If next pc == HALT_ADDR go to HALT, else go to FETCH.
- Latency with same-cycle ack: 2 cycles for ALU/LDI/BNZ; 3 cycles for LD/ST. Each wait cycle on an ack adds one cycle.
- start while busy: ignored.
- Ack seen while its req is low: ignored.
- BNZ with offset 0 and reg[ra] != 0: infinite loop (legal, no special handling).
- done stays high in HALT until start; it drops on the cycle after start is sampled.
- Register state is preserved across HALT → restart; only reset clears it.

Test Plan:
- LDI r1,5; LDI r2,3; ADD r1,r2; HALT_ADDR = 3, same-cycle acks → r1 = 8, retired = 3, done rises 6 cycles after start, busy low when done is high.
- LDI r1,0; LDI r2,1; SUB r1,r2 → r1 = 0xFF (DW = 8 wrap); XOR r1,r1 → r1 = 0.
- ST r3→[r4] then LD r5←[r4], with r3 = 0xA5, r4 = 7, dmem_ack delayed 2 cycles → dmem_req/addr/wdata stable for 3 cycles each access, dmem_we = 1 then 0, r5 = 0xA5, each memory instruction takes 5 cycles.
- Countdown loop: LDI r1,3; LDI r2,1; SUB r1,r2; BNZ r1,-1 (rb = 3'b111) → BNZ taken twice then falls through, pc sequence 0,1,2,3,2,3,2,3,4; retired = 8.
- HALT then start pulse → pc = START_ADDR, retired = 0, done falls the cycle after start is sampled; start asserted during FETCH → no effect.
- rst_n dropped mid-FETCH with imem_req high (and separately mid-MEM) → imem_req/dmem_req fall immediately, registers = 0, state IDLE; execution resumes correctly only after a new start.
